// File: rtl/btn_pkg.sv
// Shared types and default thresholds for the button event classifier.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int unsigned BTN_LONG_DEF   = 50_000_000;
  localparam int unsigned BTN_REPEAT_DEF = 10_000_000;

endpackage

// File: rtl/btn_event_edge_detect.sv
// Rise/fall detector owning the previous-sample register; reset value is a
// parameter so a button held through reset does not look like a fresh press.
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= RST_VAL;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/btn_event.sv
// Button event classifier: press/release/short/long/auto-repeat pulses from a
// debounced level. Auto-repeat is compiled in only when BTN_REPEAT_EN is defined.
// state   | meaning
// IDLE    | button released; counter held at 0
// PRESSED | held, long threshold not yet reached
// LONG    | held past long threshold; counter times repeats
module btn_event
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = BTN_LONG_DEF,
  parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_DEF,
  parameter int unsigned CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      (64'd1 << CNT_W) <= 64'(LONG_CYCLES) ||
      (64'd1 << CNT_W) <= 64'(REPEAT_CYCLES)) begin : g_param_err
    $error("btn_event: illegal LONG_CYCLES/REPEAT_CYCLES/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);

  btn_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             rise, fall;
  logic             press_nx, release_nx, short_nx, long_nx;

  edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (btn_in),
    .rise (rise),
    .fall (fall)
  );

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_nx;
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    short_nx   = 1'b0;
    long_nx    = 1'b0;
`ifdef BTN_REPEAT_EN
    repeat_nx  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rise) begin
          state_nx = PRESSED;
          press_nx = 1'b1;
        end
      end
      PRESSED: begin
        // release wins over a threshold hit in the same cycle
        if (fall) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
          short_nx   = 1'b1;
        end else if (cnt == LONG_TC) begin
          state_nx = LONG;
          cnt_nx   = '0;
          long_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (fall) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else begin
`ifdef BTN_REPEAT_EN
          if (cnt == REPEAT_TC) begin
            cnt_nx    = '0;
            repeat_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      short_pulse   <= short_nx;
      long_pulse    <= long_nx;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= repeat_nx;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  assign held = (state != IDLE);

endmodule

// File: tb/tb_btn_event.sv
// Self-checking bench for btn_event with LONG_CYCLES=8, REPEAT_CYCLES=4; the
// reference model derives every pulse from how long the button has been held.
module tb_btn_event;

  localparam int LONG = 8;
  localparam int REP  = 4;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

  btn_event #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .CNT_W         (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: m_d = cycles since the press edge; pulses follow from m_d alone
  bit       m_prev;
  bit       m_active;
  int       m_d;
  bit       m_long;
  logic [5:0] exp_v;
  wire  [5:0] dut_v = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held};

  task automatic model_reset();
    m_prev   = 1'b1;
    m_active = 1'b0;
    m_d      = 0;
    m_long   = 1'b0;
    exp_v    = '0;
  endtask

  task automatic model_edge(input bit b);
    bit p, r, s, l, rp;
    p = 0; r = 0; s = 0; l = 0; rp = 0;
    if (m_active) begin
      if (!b) begin
        r = 1;
        s = !m_long;
        m_active = 0;
      end else begin
        m_d++;
        if (m_d == LONG) begin
          l = 1;
          m_long = 1;
        end else if (REP_EN && m_d > LONG && ((m_d - LONG) % REP) == 0) begin
          rp = 1;
        end
      end
    end else if (b && !m_prev) begin
      p = 1;
      m_active = 1;
      m_d = 0;
      m_long = 0;
    end
    m_prev = b;
    exp_v = {p, r, s, l, rp, m_active};
  endtask

  task automatic cycle(input bit b);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_v !== 6'b0) $display("FAIL reset_outputs: got %b expected %b", dut_v, 6'b0);
    if (dut_v !== 6'b0) errors++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle step %0d: got %b expected %b", i, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_short();
    int p_idx, r_idx, held_n, long_n;
    bit stim[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    p_idx = -1; r_idx = -1; held_n = 0; long_n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(stim[i]);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL short_model step %0d: got %b expected %b", i, dut_v, exp_v);
      end
      if (press_pulse) p_idx = i;
      if (release_pulse && short_pulse) r_idx = i;
      if (held) held_n++;
      if (long_pulse) long_n++;
    end
    checks++;
    if (r_idx - p_idx !== 3 || p_idx !== 0) begin
      errors++;
      $display("FAIL short_timing: press at %0d release at %0d, required 0 and 3", p_idx, r_idx);
    end
    checks++;
    if (held_n !== 3 || long_n !== 0) begin
      errors++;
      $display("FAIL short_held: held %0d long %0d, required 3 and 0", held_n, long_n);
    end
  endtask

  task automatic test_hold();
    int p_idx, l_idx, rp_first, rp_n, r_idx, s_n;
    p_idx = -1; l_idx = -1; rp_first = -1; rp_n = 0; r_idx = -1; s_n = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(i < 20);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL hold_model step %0d: got %b expected %b", i, dut_v, exp_v);
      end
      if (press_pulse) p_idx = i;
      if (long_pulse) l_idx = i;
      if (repeat_pulse) begin
        rp_n++;
        if (rp_first < 0) rp_first = i;
      end
      if (release_pulse) r_idx = i;
      if (short_pulse) s_n++;
    end
    checks++;
    if (l_idx - p_idx !== LONG) begin
      errors++;
      $display("FAIL hold_long: long %0d cycles after press, required %0d", l_idx - p_idx, LONG);
    end
    checks++;
    if (rp_n !== (REP_EN ? 2 : 0) || rp_first !== (REP_EN ? l_idx + REP : -1)) begin
      errors++;
      $display("FAIL hold_repeat: count %0d first %0d, required %0d and %0d",
               rp_n, rp_first, REP_EN ? 2 : 0, REP_EN ? l_idx + REP : -1);
    end
    checks++;
    if (r_idx !== 20 || s_n !== 0) begin
      errors++;
      $display("FAIL hold_release: release at %0d shorts %0d, required 20 and 0", r_idx, s_n);
    end
  endtask

  task automatic test_boundary();
    int r_idx, long_n;
    r_idx = -1; long_n = 0;
    for (int i = 0; i < 11; i++) begin
      cycle(i < LONG);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL boundary_model step %0d: got %b expected %b", i, dut_v, exp_v);
      end
      if (release_pulse && short_pulse) r_idx = i;
      if (long_pulse) long_n++;
    end
    checks++;
    if (r_idx !== LONG || long_n !== 0) begin
      errors++;
      $display("FAIL boundary_priority: short release at %0d long %0d, required %0d and 0",
               r_idx, long_n, LONG);
    end
  endtask

  task automatic test_reset_in_long();
    int pulse_n, p_idx;
    for (int i = 0; i < 10; i++) cycle(1'b1);
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL rst_long_pre: held %b required 1", held);
    end
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_v !== 6'b0) begin
      errors++;
      $display("FAIL rst_long_async: got %b expected %b", dut_v, 6'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_n = 0; p_idx = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(i < 6 || i >= 8);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL rst_long_model step %0d: got %b expected %b", i, dut_v, exp_v);
      end
      if (i < 8 && dut_v !== 6'b0) pulse_n++;
      if (press_pulse) p_idx = i;
    end
    checks++;
    if (pulse_n !== 0 || p_idx !== 8) begin
      errors++;
      $display("FAIL rst_long_repress: stray %0d press at %0d, required 0 and 8", pulse_n, p_idx);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0);
  endtask

  task automatic test_single();
    bit stim[5] = '{0, 1, 0, 0, 0};
    logic [5:0] seen[5];
    for (int i = 0; i < 5; i++) begin
      cycle(stim[i]);
      seen[i] = dut_v;
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL single_model step %0d: got %b expected %b", i, dut_v, exp_v);
      end
    end
    checks++;
    if (seen[1] !== 6'b100001 || seen[2] !== 6'b011000) begin
      errors++;
      $display("FAIL single_pulse: got %b,%b required 100001,011000", seen[1], seen[2]);
    end
  endtask

  task automatic test_random();
    int len, gap;
    for (int n = 0; n < 30; n++) begin
      len = int'($urandom_range(1, 26));
      gap = int'($urandom_range(1, 5));
      for (int i = 0; i < len + gap; i++) begin
        cycle(i < len);
        checks++;
        if (dut_v !== exp_v) begin
          errors++;
          $display("FAIL random press %0d len %0d step %0d: got %b expected %b",
                   n, len, i, dut_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_hold();
    test_boundary();
    test_reset_in_long();
    test_single();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event.md
# btn_event

Button event classifier sitting directly downstream of `debounce`. Consumes the clean, debounced button level and converts it into single-cycle event pulses for the register-file control logic: press, release, short click, long press, and optional auto-repeat while held. Contains one FSM and one hold-time counter; all outputs are registered.

## Interface

**Parameters**
- `LONG_CYCLES`, default 50_000_000: hold time that qualifies a long press (0.5 s at 100 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period after a long press; must be ≥ 2.
- `CNT_W`, default 26: counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

**Ports**
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `btn_in` in 1: debounced button level from `debounce.btn_out`; 1 = pressed.
- `press_pulse` out 1: one-cycle pulse on press.
- `release_pulse` out 1: one-cycle pulse on release.
- `short_pulse` out 1: one-cycle pulse on a release that occurs before the long threshold.
- `long_pulse` out 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse` out 1: one-cycle pulse every `REPEAT_CYCLES` while held after a long press.
- `held` out 1: high while the FSM is not IDLE.

## Operation

- An edge register `prev` samples `btn_in` every cycle.
  - rise = `btn_in & ~prev`
  - fall = `~btn_in & prev`
- FSM states: IDLE, PRESSED, LONG.
  - IDLE, rise → PRESSED. Assert `press_pulse`. Clear counter to 0.
  - PRESSED, fall → IDLE. Assert `release_pulse` and `short_pulse`.
  - PRESSED, counter == `LONG_CYCLES`-1 with no fall → LONG. Assert `long_pulse`. Clear counter.
  - PRESSED, otherwise → counter += 1.
  - LONG, fall → IDLE. Assert `release_pulse` only.
  - LONG, counter == `REPEAT_CYCLES`-1 with no fall → assert `repeat_pulse`, clear counter, stay in LONG (only when repeat is compiled in).
  - LONG, otherwise → counter += 1.
- Counter rules: the counter only advances in PRESSED or LONG. It is held at 0 in IDLE and never wraps.
- Release has priority over threshold: a fall in the same cycle the counter hits its threshold produces release (and short, if in PRESSED), with no long or repeat pulse.
- Pulses are mutually exclusive per cycle, except `release_pulse` + `short_pulse`, which are always asserted together.

## Timing

- Event latency is 1 cycle. If edge k is the first edge to sample the new `btn_in` value, the corresponding pulse is high for exactly the cycle after edge k.
- `long_pulse` is asserted exactly `LONG_CYCLES` cycles after `press_pulse`.
- `repeat_pulse` is asserted exactly `REPEAT_CYCLES` cycles after `long_pulse`, then every `REPEAT_CYCLES` cycles after that.
- `held` rises in the same cycle as `press_pulse` and falls in the same cycle as `release_pulse`.
- Reset values: every pulse output = 0, `held` = 0, state = IDLE, counter = 0, `prev` = 1.
- Because `prev` resets to 1, a button that is held through reset deassertion generates no `press_pulse`. It must be released and pressed again.
- Reset asserted mid-press clears the outputs asynchronously. No release pulse is emitted for the aborted press.
- A one-cycle-high `btn_in` is legal and produces `press_pulse` followed immediately by `release_pulse` + `short_pulse`.

## Configuration

- `BTN_REPEAT_EN` defined: the LONG-state repeat counter and `repeat_pulse` generation are compiled in.
- Undefined: `repeat_pulse` is tied to 0, the counter stops in LONG, and `REPEAT_CYCLES` is ignored.

## Structure

- Shared package `btn_pkg` holds:
  - the state enum `btn_state_t` {IDLE, PRESSED, LONG};
  - default threshold constants `BTN_LONG_DEF` and `BTN_REPEAT_DEF`.
- One sub-module, `edge_detect`, owns the `prev` register. Its ports are `clk`, `rst`, `sig`, `rise`, `fall`, and its reset value is a parameter (1 here).

## Test plan

Run with `LONG_CYCLES`=8, `REPEAT_CYCLES`=4.

- Press for 3 cycles, then release → `press_pulse` in 1 cycle; `release_pulse` + `short_pulse` in 1 cycle together, 3 cycles after `press_pulse`; no `long_pulse`; `held` high for 3 cycles.
- Hold for 20 cycles with `BTN_REPEAT_EN` defined → `long_pulse` 8 cycles after `press_pulse`; `repeat_pulse` at +4 and +8 after that (no third, since the release occurs just before it); release → `release_pulse` with no `short_pulse`.
- Same hold without `BTN_REPEAT_EN` → single `long_pulse` at +8; `repeat_pulse` never asserts.
- Release timed to fall in the cycle the counter equals 7 → `short_pulse` + `release_pulse`; no `long_pulse`.
- Assert `rst` while in LONG with `btn_in` held high → all outputs 0 immediately. After deassert, no pulses while the button stays held. Release then re-press → normal `press_pulse`.
- Single-cycle high `btn_in` → `press_pulse`, then on the next cycle `release_pulse` + `short_pulse`.
